// File: rtl/four_12_12_st1_ctrl_pkg.sv
// rtl/four_12_12_st1_ctrl_pkg.sv - shared types and constants for the stage-1 memory sequencer
package four_12_12_st1_ctrl_pkg;

  localparam int ST1_TAP_W  = 384;
  localparam int ST1_WORD_W = 32;

  typedef struct packed {
    logic       rd_en;
    logic       wr_en;
    logic [4:0] addr;
  } tap_int_384_5;

  typedef struct packed {
    logic       rd_en;
    logic       wr_en;
    logic [3:0] addr;
  } bias_int_32_4;

  typedef struct packed {
    logic       rd_en;
    logic       wr_en;
    logic [8:0] addr;
  } data_int_32_9;

  typedef enum logic [1:0] {
    SEL_TAP  = 2'd0,
    SEL_BIAS = 2'd1,
    SEL_DATA = 2'd2
  } host_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_COEF  = 2'd2,
    ST_DRAIN = 2'd3
  } st1_state_e;

  // One buffered beat: word carries the data word or the bias, tap is only used by coef beats.
  typedef struct packed {
    logic                  kind;
    logic [ST1_WORD_W-1:0] word;
    logic [ST1_TAP_W-1:0]  tap;
  } st1_beat_t;

endpackage

// File: rtl/four_12_12_st1_ctrl_skid.sv
// rtl/four_12_12_st1_ctrl_skid.sv - 2-entry output buffer with read-in-flight credit
// Read data bypasses straight to the port when the buffer is empty and the MAC is ready.
module four_12_12_st1_ctrl_skid
  import four_12_12_st1_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_issue,
  input  logic                  rd_kind,
  input  logic [ST1_WORD_W-1:0] data_rd,
  input  logic [ST1_WORD_W-1:0] bias_rd,
  input  logic [ST1_TAP_W-1:0]  tap_rd,
  output logic                  credit_ok,
  output logic                  empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_kind,
  output logic [ST1_WORD_W-1:0] out_data,
  output logic [ST1_TAP_W-1:0]  out_tap,
  output logic [ST1_WORD_W-1:0] out_bias
);

  logic      inflight_q, inflight_d;
  logic      kind_q, kind_d;
  logic [1:0] occ_q, occ_d;
  logic      wr_ptr_q, wr_ptr_d;
  logic      rd_ptr_q, rd_ptr_d;
  st1_beat_t ent_q [2];
  st1_beat_t ent_d [2];
  st1_beat_t in_beat;
  st1_beat_t head;
  logic      pop;
  logic      pop_stored;
  logic      push;

  always_comb begin
    in_beat.kind = kind_q;
    in_beat.word = kind_q ? bias_rd : data_rd;
    in_beat.tap  = kind_q ? tap_rd : '0;
    head         = (occ_q != 2'd0) ? ent_q[rd_ptr_q] : in_beat;

    out_valid  = (occ_q != 2'd0) || inflight_q;
    pop        = out_valid && out_ready;
    pop_stored = pop && (occ_q != 2'd0);
    // Arriving data is stored unless it leaves through the bypass this very cycle.
    push       = inflight_q && ((occ_q != 2'd0) || !out_ready);

    occ_d = occ_q;
    if (push) occ_d = occ_d + 2'd1;
    if (pop_stored) occ_d = occ_d - 2'd1;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop_stored;
    ent_d    = ent_q;
    if (push) ent_d[wr_ptr_q] = in_beat;

    inflight_d = rd_issue;
    kind_d     = rd_kind;

    credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
    empty     = (occ_q == 2'd0) && !inflight_q;

    out_kind = out_valid && head.kind;
    out_data = (out_valid && !head.kind) ? head.word : '0;
    out_bias = (out_valid && head.kind) ? head.word : '0;
    out_tap  = (out_valid && head.kind) ? head.tap : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      kind_q     <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ent_q      <= '{default: '0};
    end else begin
      inflight_q <= inflight_d;
      kind_q     <= kind_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ent_q      <= ent_d;
    end
  end

endmodule

// File: rtl/four_12_12_st1_ctrl.sv
// rtl/four_12_12_st1_ctrl.sv - stage-1 job sequencer and host/sequencer memory port arbiter
// Optional stall counter: FOUR_12_12_ST1_CTRL_PERF_EN.
module four_12_12_st1_ctrl
  import four_12_12_st1_ctrl_pkg::*;
#(
  parameter int NUM_OUT = 12,
  parameter int NUM_IN  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8:0]            base_addr,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [1:0]            host_sel,
  input  logic [8:0]            host_addr,
  input  logic [ST1_TAP_W-1:0]  host_data,
  output tap_int_384_5          tap_int,
  output bias_int_32_4          bias_int,
  output data_int_32_9          data_int,
  output logic [ST1_TAP_W-1:0]  tap_int_wr_data,
  output logic [ST1_WORD_W-1:0] bias_int_wr_data,
  output logic [ST1_WORD_W-1:0] data_int_wr_data,
  input  logic [ST1_TAP_W-1:0]  tap_int_rd_data,
  input  logic [ST1_WORD_W-1:0] bias_int_rd_data,
  input  logic [ST1_WORD_W-1:0] data_int_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_kind,
  output logic [ST1_WORD_W-1:0] out_data,
  output logic [ST1_TAP_W-1:0]  out_tap,
  output logic [ST1_WORD_W-1:0] out_bias,
  output logic [15:0]           stall_cnt
);

  localparam int CNT_W = $clog2((NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(NUM_OUT - 1);

  st1_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       base_q, base_d;
  logic             seq_rd;
  logic             data_rd;
  logic             coef_rd;
  logic             credit_ok;
  logic             empty;
  logic             host_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    seq_rd  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (credit_ok) begin
          seq_rd = 1'b1;
          if (cnt_q == LAST_IN) begin
            cnt_d   = '0;
            state_d = ST_COEF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COEF: begin
        if (credit_ok) begin
          seq_rd = 1'b1;
          if (cnt_q == LAST_OUT) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign data_rd = seq_rd && (state_q == ST_DATA);
  assign coef_rd = seq_rd && (state_q == ST_COEF);

  // Sequencer reads always win; the host only gets the port its target memory leaves idle.
  always_comb begin
    case (host_sel)
      SEL_TAP:  host_ready = !coef_rd;
      SEL_BIAS: host_ready = !coef_rd;
      SEL_DATA: host_ready = !data_rd;
      default:  host_ready = 1'b1;
    endcase
    host_ready = host_ready && reset;
    host_fire  = host_valid && host_ready;
  end

  always_comb begin
    tap_int          = '0;
    bias_int         = '0;
    data_int         = '0;
    tap_int_wr_data  = '0;
    bias_int_wr_data = '0;
    data_int_wr_data = '0;
    if (coef_rd) begin
      tap_int.rd_en  = 1'b1;
      tap_int.addr   = 5'(cnt_q);
      bias_int.rd_en = 1'b1;
      bias_int.addr  = 4'(cnt_q);
    end else if (host_fire && host_sel == SEL_TAP) begin
      tap_int.wr_en   = 1'b1;
      tap_int.addr    = host_addr[4:0];
      tap_int_wr_data = host_data;
    end else if (host_fire && host_sel == SEL_BIAS) begin
      bias_int.wr_en   = 1'b1;
      bias_int.addr    = host_addr[3:0];
      bias_int_wr_data = host_data[ST1_WORD_W-1:0];
    end
    if (data_rd) begin
      data_int.rd_en = 1'b1;
      data_int.addr  = base_q + 9'(cnt_q);
    end else if (host_fire && host_sel == SEL_DATA) begin
      data_int.wr_en   = 1'b1;
      data_int.addr    = host_addr;
      data_int_wr_data = host_data[ST1_WORD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  four_12_12_st1_ctrl_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .rd_issue  (seq_rd),
    .rd_kind   (coef_rd),
    .data_rd   (data_int_rd_data),
    .bias_rd   (bias_int_rd_data),
    .tap_rd    (tap_int_rd_data),
    .credit_ok (credit_ok),
    .empty     (empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data),
    .out_tap   (out_tap),
    .out_bias  (out_bias)
  );

`ifdef FOUR_12_12_ST1_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && start) begin
      stall_cnt_d = '0;
    end else if (busy && out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_four_12_12_st1_ctrl.sv
// tb/tb_four_12_12_st1_ctrl.sv - scoreboard bench for the stage-1 sequencer/arbiter
module tb_four_12_12_st1_ctrl;
  import four_12_12_st1_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [8:0]   base_addr = '0;
  logic         busy, done;
  logic         host_valid = 1'b0;
  logic         host_ready;
  logic [1:0]   host_sel = '0;
  logic [8:0]   host_addr = '0;
  logic [383:0] host_data = '0;
  tap_int_384_5 tap_int;
  bias_int_32_4 bias_int;
  data_int_32_9 data_int;
  logic [383:0] tap_int_wr_data;
  logic [31:0]  bias_int_wr_data, data_int_wr_data;
  logic [383:0] tap_int_rd_data;
  logic [31:0]  bias_int_rd_data, data_int_rd_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_kind;
  logic [31:0]  out_data, out_bias;
  logic [383:0] out_tap;
  logic [15:0]  stall_cnt;

  four_12_12_st1_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done),
    .host_valid(host_valid), .host_ready(host_ready), .host_sel(host_sel),
    .host_addr(host_addr), .host_data(host_data),
    .tap_int(tap_int), .bias_int(bias_int), .data_int(data_int),
    .tap_int_wr_data(tap_int_wr_data), .bias_int_wr_data(bias_int_wr_data),
    .data_int_wr_data(data_int_wr_data),
    .tap_int_rd_data(tap_int_rd_data), .bias_int_rd_data(bias_int_rd_data),
    .data_int_rd_data(data_int_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_data(out_data), .out_tap(out_tap), .out_bias(out_bias),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Memory bank model driven by the DUT's control structs.
  logic [383:0] tap_mem  [32];
  logic [31:0]  bias_mem [16];
  logic [31:0]  data_mem [512];
  always @(posedge clk) begin
    if (tap_int.rd_en)  tap_int_rd_data  <= tap_mem[tap_int.addr];
    if (tap_int.wr_en)  tap_mem[tap_int.addr] <= tap_int_wr_data;
    if (bias_int.rd_en) bias_int_rd_data <= bias_mem[bias_int.addr];
    if (bias_int.wr_en) bias_mem[bias_int.addr] <= bias_int_wr_data;
    if (data_int.rd_en) data_int_rd_data <= data_mem[data_int.addr];
    if (data_int.wr_en) data_mem[data_int.addr] <= data_int_wr_data;
  end

  // Reference contents as the host intended them.
  logic [383:0] ref_tap  [32];
  logic [31:0]  ref_bias [16];
  logic [31:0]  ref_data [512];

  typedef struct {
    logic         kind;
    logic [31:0]  d;
    logic [383:0] t;
    logic [31:0]  b;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;

  always @(posedge clk) cyc++;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and records job timing events.
  int           done_cnt = 0, done_cyc = -1, stall_obs = 0;
  int           busy_rise = -1, busy_fall = -1, valid_first = -1;
  logic         busy_prev = 1'b0, need_valid = 1'b0, hold_v = 1'b0;
  logic [448:0] hold_pl;
  exp_t         e;
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy && !busy_prev) begin busy_rise = cyc; need_valid = 1'b1; end
      if (!busy && busy_prev) busy_fall = cyc;
      busy_prev = busy;
      if (out_valid && need_valid) begin valid_first = cyc; need_valid = 1'b0; end
      if (busy && out_valid && !out_ready) stall_obs++;
      if (hold_v && out_valid) begin
        tests++;
        if ({out_kind, out_data, out_tap, out_bias} != hold_pl) begin
          fails++;
          $display("FAIL hold_stable cyc=%0d: payload changed while stalled", cyc);
        end
      end
      hold_v  = out_valid && !out_ready;
      hold_pl = {out_kind, out_data, out_tap, out_bias};
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_extra cyc=%0d: got kind=%0d data=%0h bias=%0h, required no beat",
                   cyc, out_kind, out_data, out_bias);
        end else begin
          e = exp_q.pop_front();
          if (out_kind !== e.kind || out_data !== e.d || out_tap !== e.t || out_bias !== e.b) begin
            fails++;
            $display("FAIL beat cyc=%0d: got kind=%0d data=%0h bias=%0h tap0=%0h, required kind=%0d data=%0h bias=%0h tap0=%0h",
                     cyc, out_kind, out_data, out_bias, out_tap[31:0], e.kind, e.d, e.b, e.t[31:0]);
          end
        end
      end
    end else begin
      hold_v    = 1'b0;
      busy_prev = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input int a, input logic [383:0] d,
                            output int fc, output logic data_rd_at_fire);
    int n = 0;
    host_valid = 1'b1;
    host_sel   = sel;
    host_addr  = 9'(a);
    host_data  = d;
    @(negedge clk);
    while (!host_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    fc = cyc;
    data_rd_at_fire = data_int.rd_en;
    chk("host_ready_timeout", 64'(host_ready), 64'd1);
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    case (sel)
      2'd0: ref_tap[a % 32]  = d;
      2'd1: ref_bias[a % 16] = d[31:0];
      2'd2: ref_data[a % 512] = d[31:0];
      default: ;
    endcase
  endtask

  task automatic run_job(input int base, input int mode, output int t0);
    exp_t x;
    ready_mode = mode;
    for (int i = 0; i < 12; i++) begin
      x.kind = 1'b0; x.d = ref_data[(base + i) % 512]; x.t = '0; x.b = '0;
      exp_q.push_back(x);
    end
    for (int n = 0; n < 12; n++) begin
      x.kind = 1'b1; x.d = '0; x.t = ref_tap[n]; x.b = ref_bias[n];
      exp_q.push_back(x);
    end
    start     = 1'b1;
    base_addr = 9'(base);
    t0        = cyc;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("job_done_seen", 64'(done_cnt != d0), 64'd1);
    tick(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_host_ready"}, 64'(host_ready), 64'd0);
    chk({tag, "_mem_ctl"}, 64'({tap_int, bias_int, data_int}), 64'd0);
    chk({tag, "_wr_data"}, 64'(|{tap_int_wr_data, bias_int_wr_data, data_int_wr_data}), 64'd0);
    chk({tag, "_payload"}, 64'(|{out_kind, out_data, out_tap, out_bias}), 64'd0);
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  int   t0, d0, s0, fc, base;
  logic rdf;
  logic [31:0] v;

  initial begin
    // Reset state, with a host request pending so host_ready is meaningful.
    host_valid = 1'b1;
    host_sel   = 2'd2;
    tick(3);
    @(negedge clk);
    check_zero_outputs("reset");
    host_valid = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);

    for (int n = 0; n < 12; n++) begin
      host_write(2'd0, n, {12{32'(n)}}, fc, rdf);
      host_write(2'd1, n, 384'(100 + n), fc, rdf);
      host_write(2'd2, n, 384'(n), fc, rdf);
    end
    for (int a = 500; a < 512; a++) host_write(2'd2, a, 384'($urandom), fc, rdf);

    // Back-to-back job with the MAC always ready: exact latency profile.
    d0 = done_cnt;
    run_job(0, 0, t0);
    wait_done(d0);
    chk("t1_busy_cycle", 64'(busy_rise - t0), 64'd1);
    chk("t1_first_valid", 64'(valid_first - t0), 64'd2);
    chk("t1_done_cycle", 64'(done_cyc - t0), 64'd26);
    chk("t1_busy_low", 64'(busy_fall - t0), 64'd27);

    // Ready 1-of-3 with a data write slipped into a DATA-phase gap.
    d0 = done_cnt;
    s0 = stall_obs;
    run_job(0, 1, t0);
    tick(2);
    v = $urandom;
    host_write(2'd2, 511, 384'(v), fc, rdf);
    chk("t2_write_in_gap", 64'(rdf), 64'd0);
    chk("t2_write_during_job", 64'(fc - t0 < 40), 64'd1);
    wait_done(d0);
`ifdef FOUR_12_12_ST1_CTRL_PERF_EN
    chk("t2_stall_cnt", 64'(stall_cnt), 64'(stall_obs - s0));
`else
    chk("t2_stall_cnt_tied", 64'(stall_cnt), 64'd0);
`endif

    // Wrapping base address.
    d0 = done_cnt;
    run_job(506, 0, t0);
    wait_done(d0);

    // Bias write held through COEF: must land in the first cycle after the last coef read.
    d0 = done_cnt;
    run_job(0, 0, t0);
    tick(13);
    host_write(2'd1, 5, 384'(32'h0000_5555), fc, rdf);
    chk("t4_bias_write_cycle", 64'(fc - t0), 64'd25);
    wait_done(d0);

    // start while busy must be ignored.
    d0 = done_cnt;
    run_job(0, 0, t0);
    tick(4);
    start     = 1'b1;
    base_addr = 9'd100;
    tick(1);
    start     = 1'b0;
    wait_done(d0);
    tick(40);
    chk("t5_single_done", 64'(done_cnt - d0), 64'd1);
    chk("t5_idle_after", 64'(busy), 64'd0);

    // Reset mid-job, then a full job under random backpressure.
    run_job(0, 0, t0);
    tick(9);
    host_valid = 1'b1;
    host_sel   = 2'd0;
    reset      = 1'b0;
    @(negedge clk);
    check_zero_outputs("t6_reset");
    host_valid = 1'b0;
    exp_q.delete();
    tick(1);
    reset = 1'b1;
    tick(2);
    d0 = done_cnt;
    run_job(0, 2, t0);
    wait_done(d0);

    // Randomized jobs: fresh data, truncated bias address, dropped sel=3 write.
    for (int k = 0; k < 4; k++) begin
      base = $urandom_range(0, 511);
      for (int i = 0; i < 12; i++) host_write(2'd2, (base + i) % 512, 384'($urandom), fc, rdf);
      host_write(2'd1, 16 * $urandom_range(1, 31) + $urandom_range(0, 11), 384'($urandom), fc, rdf);
      host_write(2'd0, 32 * $urandom_range(1, 15) + $urandom_range(0, 11),
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, fc, rdf);
      host_write(2'd3, $urandom_range(0, 11), {12{$urandom}}, fc, rdf);
      d0 = done_cnt;
      s0 = stall_obs;
      run_job(base, $urandom_range(0, 2), t0);
      wait_done(d0);
`ifdef FOUR_12_12_ST1_CTRL_PERF_EN
      chk("rand_stall_cnt", 64'(stall_cnt), 64'(stall_obs - s0));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/four_12_12_st1_ctrl.md
# four_12_12_st1_ctrl

Sequencer and arbiter for the stage-1 memory bank (tap 32×384, bias 16×32, data 512×32). On `start` it streams one 12-word input vector from data memory, then 12 tap-row/bias pairs, to the stage-1 MAC through a ready/valid port. It also shares each memory's control port between that sequence and a host load port. It sits between the host/DMA loader and the `four_12_12_st1_mem` instance, and drives its `tap_int`/`bias_int`/`data_int` control structs and write data.

## Interface
- `NUM_OUT`, 12: neurons, equal to the tap/bias rows read per job.
- `NUM_IN`, 12: data words per vector.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: job request. Sampled in IDLE only.
- `base_addr` in 9: data address of word 0, sampled with `start`.
- `busy` out 1: high from the cycle after accept until `done`.
- `done` out 1: one-cycle pulse at job end.
- `host_valid` / `host_ready` in/out 1: host write handshake.
- `host_sel` in 2: 0 = tap, 1 = bias, 2 = data. 3 is accepted and dropped.
- `host_addr` in 9: truncated to 5/4/9 bits per target.
- `host_data` in 384: tap uses [383:0]; bias/data use [31:0].
- `tap_int`, `bias_int`, `data_int` out struct: {rd_en, wr_en, addr} per memory.
- `tap_int_wr_data` out 384; `bias_int_wr_data`, `data_int_wr_data` out 32.
- `tap_int_rd_data` in 384; `bias_int_rd_data`, `data_int_rd_data` in 32. Valid 1 cycle after rd_en.
- `out_valid` / `out_ready` out/in 1: stream to MAC.
- `out_kind` out 1: 0 = data beat, 1 = coef beat.
- `out_data` out 32, `out_tap` out 384, `out_bias` out 32: payload. Fields not used by the current kind are 0.
- `stall_cnt` out 16: see Configuration.

## Operation
- FSM states: IDLE → DATA (NUM_IN reads) → COEF (NUM_OUT reads) → DRAIN → IDLE.
- DATA phase: read word i from data address (`base_addr`+i) mod 512, for i = 0..11. Wraps 511→0.
- COEF phase: row n has tap rd_en and bias rd_en asserted together at addr n, for n = 0..11.
- DRAIN phase: wait for the output buffer to empty, then pulse `done` and return to IDLE.
- Output buffer: 2 entries. A read issues only if (occupancy + reads in flight) < 2, so no beat is lost under backpressure.
- Arbitration is per memory and per cycle. A sequencer read wins. A host write proceeds only when the target memory has no read that cycle.
  - `host_ready` = 1 when that condition holds for `host_sel`.
  - A write occurs on `host_valid & host_ready`. It drives wr_en/addr/wr_data that cycle.
- Host writes during a job are allowed. A write to a row not yet read is seen by that job. No other ordering is guaranteed.
- `start` while busy is ignored; there is no queueing.
- Reset: FSM returns to IDLE, buffer and counters clear.
  - Outputs go to 0: `busy`, `done`, `out_valid`, `host_ready`, all rd_en/wr_en/addr, all write data, `stall_cnt`.
  - Read data in flight when reset hits is discarded.

## Timing
- Cycle 0: `start` accepted.
- Cycle 1: `busy` = 1 and the first data rd_en.
- Cycle 2: first `out_valid`.
- With `out_ready` held high: one read per cycle and no idle cycle at the DATA→COEF switch. The last beat is at cycle 25, `done` at cycle 26 and `busy` low at cycle 27.
- Next `start` can be accepted at cycle 27.
- Payload and `out_kind` stay stable while `out_valid` is high and `out_ready` is low.

## Configuration
- `FOUR_12_12_ST1_CTRL_PERF_EN` defined: `stall_cnt` counts cycles with `out_valid & ~out_ready` during `busy`.
  - Clears on job accept.
  - Saturates at 0xFFFF.
- Macro undefined: `stall_cnt` is tied to 0 and no counter flops are generated.

## Structure
- Shared package holds:
  - The memory control struct types `tap_int_384_5`, `bias_int_32_4`, `data_int_32_9`.
  - A `host_sel` enum (TAP / BIAS / DATA).
  - An FSM state enum.
  - Constants `ST1_TAP_W` = 384 and `ST1_WORD_W` = 32.
- Sub-module `four_12_12_st1_ctrl_skid`: the 2-entry output buffer with occupancy and in-flight credit.

## Test plan
- Host writes tap rows 0..11 = {12{n}}, bias n = 100+n and data 0..11 = i. Then `start`, base 0, with `out_ready` = 1.
  - Expect 12 data beats 0..11, then 12 coef beats (tap = {12{n}}, bias = 100+n).
  - Expect `done` at cycle 26.
- `base_addr` = 506 → data addresses 506..511 then 0..5, in order.
- Toggle `out_ready` 1-of-3 cycles → same 24 beats in order, no drops or duplicates. With PERF_EN, `stall_cnt` equals the observed stall cycles.
- Host bias write held valid during the COEF phase → `host_ready` low while bias reads run, and the write commits in the first cycle after COEF. A simultaneous tap-free data write is accepted in DATA-phase gaps only.
- `start` pulsed at cycle 5 of a running job → ignored, exactly one `done`.
- Assert `reset` low at cycle 10 of a job → all outputs 0 next edge. After release, a new job produces the full 24 beats correctly.
